// File: rtl/bus_mon_uart.sv
// Host bus monitor with UART output.
// Samples the 8080-style host bus of an S1D13700 (write and optionally read strobes) and an
// optional STN FPFRAME marker, tags each event with a 3-bit sequence number, queues it in a
// FIFO and sends every entry as two 8N1 bytes (header, then data) on sout.
//
// Ports:
//   clk     - monitor clock
//   rst_x   - asynchronous active-low reset
//   ce_x    - host chip select, active low (asynchronous to clk)
//   a0      - host address (0 = data, 1 = command)
//   wr_x    - host write strobe, active low
//   rd_x    - host read strobe, active low
//   dat     - host data bus
//   fpframe - STN frame sync, active high
//   sout    - UART serial output, idle high
//   busy    - FIFO non-empty or UART frame in progress
//   ovf     - sticky overflow flag
//
// Header byte: {1'b1, type[1:0], a0, lost, seq[2:0]}; type 00 = write, 01 = read, 10 = frame.
module bus_mon_uart #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CAP_RD     = 1,
  parameter int unsigned CAP_FRM    = 1
) (
  input  logic       clk,
  input  logic       rst_x,
  input  logic       ce_x,
  input  logic       a0,
  input  logic       wr_x,
  input  logic       rd_x,
  input  logic [7:0] dat,
  input  logic       fpframe,
  output logic       sout,
  output logic       busy,
  output logic       ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BitLast = 16'(CLK_DIV - 1);
  // Synchroniser layout {fpframe, dat[7:0], rd_x, wr_x, a0, ce_x}; reset to an idle bus.
  localparam logic [12:0] SyncIdle = 13'h000D;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StBits  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [12:0] s1_q, s2_q;
  logic [2:0]  strb_q;        // {fpframe, rd_x, wr_x} one cycle behind s2_q
  logic [8:0]  cap_q;         // {dat, a0} as held on the final strobe-low cycle

  logic        wr_ev, rd_ev, frm_ev, bus_ev;
  logic [1:0]  bus_type;

  logic [15:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        empty, full, pop, push, do_push, drop_frm;
  logic [15:0] entry;

  logic [2:0]  seq_q, seq_d, pend_seq_q, pend_seq_d;
  logic [7:0]  frm_cnt_q, frm_cnt_d, pend_cnt_q, pend_cnt_d;
  logic        pend_q, pend_d, lost_q, lost_d, ovf_q, ovf_d;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d, sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  logic        sel_q, sel_d;  // 0 = header byte, 1 = data byte
  logic        tick;
  logic [7:0]  cur_byte;

  assign wr_ev    = s2_q[2] & ~strb_q[0] & ~s2_q[0];
  assign rd_ev    = (CAP_RD != 0) & s2_q[3] & ~strb_q[1] & ~s2_q[0];
  assign frm_ev   = (CAP_FRM != 0) & s2_q[12] & ~strb_q[2];
  assign bus_ev   = wr_ev | rd_ev;
  assign bus_type = wr_ev ? 2'b00 : 2'b01;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = (state_q == StIdle) && !empty;

  // Event arbitration: a bus event wins the push slot; a coincident frame edge waits in the
  // one-deep pending register, and a further frame edge while it is occupied is dropped.
  always_comb begin
    push       = 1'b0;
    drop_frm   = 1'b0;
    entry      = '0;
    seq_d      = seq_q;
    frm_cnt_d  = frm_cnt_q;
    pend_d     = pend_q;
    pend_seq_d = pend_seq_q;
    pend_cnt_d = pend_cnt_q;
    if (bus_ev) begin
      push  = 1'b1;
      entry = {1'b1, bus_type, cap_q[0], lost_q, seq_q, cap_q[8:1]};
      if (frm_ev) begin
        frm_cnt_d = frm_cnt_q + 8'd1;
        seq_d     = seq_q + 3'd2;
        if (pend_q) begin
          drop_frm = 1'b1;
        end else begin
          pend_d     = 1'b1;
          pend_seq_d = seq_q + 3'd1;
          pend_cnt_d = frm_cnt_q;
        end
      end else begin
        seq_d = seq_q + 3'd1;
      end
    end else if (pend_q) begin
      push   = 1'b1;
      entry  = {1'b1, 2'b10, 1'b0, lost_q, pend_seq_q, pend_cnt_q};
      pend_d = frm_ev;
      if (frm_ev) begin
        pend_seq_d = seq_q;
        pend_cnt_d = frm_cnt_q;
        frm_cnt_d  = frm_cnt_q + 8'd1;
        seq_d      = seq_q + 3'd1;
      end
    end else if (frm_ev) begin
      push      = 1'b1;
      entry     = {1'b1, 2'b10, 1'b0, lost_q, seq_q, frm_cnt_q};
      frm_cnt_d = frm_cnt_q + 8'd1;
      seq_d     = seq_q + 3'd1;
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
  always_comb begin
    do_push = push & (~full | pop);
    lost_d  = lost_q;
    ovf_d   = ovf_q;
    if (drop_frm || (push && !do_push)) begin
      lost_d = 1'b1;
      ovf_d  = 1'b1;
    end else if (do_push) begin
      lost_d = 1'b0;
    end
    wptr_d = wptr_q + (AW+1)'(do_push);
    rptr_d = rptr_q + (AW+1)'(pop);
  end

  assign tick     = (cnt_q == BitLast);
  assign cur_byte = sel_q ? sh_q[7:0] : sh_q[15:8];

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    sel_d   = sel_q;
    sh_d    = sh_q;
    case (state_q)
      StIdle: begin
        cnt_d = 16'd0;
        if (!empty) begin
          sh_d    = mem_q[rptr_q[AW-1:0]];
          sel_d   = 1'b0;
          state_d = StStart;
        end
      end
      StStart: if (tick) begin
        bit_d   = 3'd0;
        state_d = StBits;
      end
      StBits: if (tick) begin
        if (bit_q == 3'd7) state_d = StStop;
        else               bit_d   = bit_q + 3'd1;
      end
      StStop: if (tick) begin
        if (!sel_q) begin
          sel_d   = 1'b1;
          state_d = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (state_q)
      StStart: sout = 1'b0;
      StBits:  sout = cur_byte[bit_q];
      default: sout = 1'b1;
    endcase
  end

  assign busy = !empty || (state_q != StIdle);
  assign ovf  = ovf_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      s1_q       <= SyncIdle;
      s2_q       <= SyncIdle;
      strb_q     <= 3'b011;
      cap_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      seq_q      <= '0;
      frm_cnt_q  <= '0;
      pend_q     <= 1'b0;
      pend_seq_q <= '0;
      pend_cnt_q <= '0;
      lost_q     <= 1'b0;
      ovf_q      <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      sel_q      <= 1'b0;
      sh_q       <= '0;
    end else begin
      s1_q       <= {fpframe, dat, rd_x, wr_x, a0, ce_x};
      s2_q       <= s1_q;
      strb_q     <= {s2_q[12], s2_q[3], s2_q[2]};
      cap_q      <= {s2_q[11:4], s2_q[1]};
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      seq_q      <= seq_d;
      frm_cnt_q  <= frm_cnt_d;
      pend_q     <= pend_d;
      pend_seq_q <= pend_seq_d;
      pend_cnt_q <= pend_cnt_d;
      lost_q     <= lost_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sel_q      <= sel_d;
      sh_q       <= sh_d;
    end
  end

endmodule

// File: doc/bus_mon_uart.md
Name: bus_mon_uart

Overview:
- Parametrised successor to the single-channel host monitor.
- Samples the S1D13700 8080-style host bus (write and, optionally, read strobes) plus an optional STN FPFRAME marker channel.
- Timestamps each event with a sequence number, buffers it in a FIFO and serialises it as 2-byte frames over an 8N1 UART on sout.
- Sits between the monitor pad wrapper and the serial output pin.

Parameters:
- CLK_DIV, 16, clocks per UART bit (legal range 2..65535).
- FIFO_DEPTH, 16, event FIFO entries (power of 2, range 4..256).
- CAP_RD, 1, 1 = capture read cycles; 0 = ignore rd_x.
- CAP_FRM, 1, 1 = capture FPFRAME rising edges as marker events; 0 = ignore.

Ports:
- clk  in  1  monitor clock (MCLKI domain)
- rst_x  in  1  asynchronous active-low reset
- ce_x  in  1  host chip select, active low, asynchronous to clk
- a0  in  1  host address (0 = data, 1 = command)
- wr_x  in  1  host write strobe, active low
- rd_x  in  1  host read strobe, active low
- dat  in  8  host data bus
- fpframe  in  1  STN frame sync, active high
- sout  out  1  UART serial output, idle high
- busy  out  1  high while the FIFO is non-empty or a UART frame is in progress
- ovf  out  1  sticky overflow; cleared only by reset

Behaviour:
- Reset (rst_x low, asynchronous):
  - sout=1, busy=0, ovf=0.
  - FIFO empty, seq=0, frame counter=0, pending flags cleared, UART idle.
  - A reset mid-frame aborts transmission immediately; sout goes to 1.
- Synchronisation: ce_x, a0, wr_x, rd_x, dat and fpframe each pass through a 2-FF synchroniser. All detection uses the synchronised copies.
- Write event: synchronised wr_x rises (0->1) while synchronised ce_x is 0 in that same cycle. Captures {type=00, a0, dat} from the synchronised stage, i.e. the values held on the final strobe-low cycle.
- Read event (CAP_RD=1 only): same rule on rd_x, type=01.
- Frame event (CAP_FRM=1 only): synchronised fpframe rises. Type=10, a0=0, data = 8-bit frame counter. The counter increments after each frame event and wraps at 255->0.
- Latency: an event is written into the FIFO on the 3rd rising clk edge after the pin edge.
- Simultaneous events: a bus event is pushed that cycle. The frame event is held in a 1-deep pending register and pushed in the next cycle that has no bus event. A second frame edge arriving while one is pending is dropped and counts as an overflow.
- Entry format (16 bits):
  - Header byte: bit7=1 (sync), bits6:5=type, bit4=a0, bit3=lost, bits2:0=seq.
  - Data byte: dat or frame count.
- seq is 3 bits. It increments on every detected event, including dropped ones, so the host can see gaps. The pushed entry carries the pre-increment value. Wraps 7->0.
- FIFO full at push time:
  - The event is dropped and ovf is set (sticky).
  - An internal lost flag is set; it goes into bit3 of the next entry that is pushed, then clears.
  - A push and a pop in the same cycle while full: the pop happens first and the push succeeds.
- UART FSM, states IDLE, START, BITS, STOP:
  - IDLE: if the FIFO is non-empty, pop the entry and go to START for the header byte.
  - START: sout=0 for CLK_DIV clocks.
  - BITS: 8 bits, LSB first, CLK_DIV clocks each.
  - STOP: sout=1 for CLK_DIV clocks.
  - After the header byte goes back to START for the data byte with no idle gap. After the data byte goes to IDLE.
  - The next pop may occur on the first IDLE cycle, giving back-to-back frames.
  - One event = 20 bit times = 20*CLK_DIV clocks.
- busy = FIFO non-empty OR FSM != IDLE.
- Bit-time counter width is 16 bits. A baud counter reload does not depend on FIFO activity.

Test Plan:
- CLK_DIV=4, reset release, write a0=1 dat=0x42 (ce_x low, wr_x low 4 clk) -> entry pushed 3 clk after wr_x rise. sout emits header 0x90 then data 0x42 (start 0, LSB first, stop 1) over 80 clk. busy falls after the final stop bit.
- CAP_RD=1, read a0=0 dat=0xA5, then CAP_RD=0 repeat -> first run sends header 0xA0 data 0xA5 (seq=0). Second run sends nothing and busy stays 0.
- fpframe pulses 3 times -> frames 0xC0/0x00, 0xC1/0x01, 0xC2/0x02. Then wr_x rise and fpframe rise in the same synchronised cycle -> write entry first, frame entry next cycle.
- FIFO_DEPTH=4, CLK_DIV=100, 7 back-to-back writes dat=0x10..0x16 -> ovf=1. Writes 0x15 and 0x16 are dropped. The next accepted write (dat=0x17) has header bit3=1 and seq=7. Subsequent headers have bit3=0.
- Assert rst_x mid-data-bit -> sout=1, busy=0 and ovf=0 asynchronously. After release, a single write produces seq=0 with a clean frame.
- wr_x toggling with ce_x high -> no event. seq is unchanged and sout stays 1.
